// File: rtl/snax_simbacore_pkg.sv
// Shared definitions for the SimbaCore launch controller: CSR map, status bits,
// controller states and the configuration record handed to the core.
package snax_simbacore_pkg;

  localparam int unsigned CfgModeWidth = 13;
  localparam int unsigned CfgDataWidth = 32;

  localparam int unsigned CsrMode    = 0;
  localparam int unsigned CsrSeqLen  = 1;
  localparam int unsigned CsrDModel  = 2;
  localparam int unsigned CsrDtRank  = 3;
  localparam int unsigned CsrDInner  = 4;
  localparam int unsigned CsrDFinal  = 5;
  localparam int unsigned CsrControl = 6;

  localparam int unsigned CtrlStartBit = 0;
  localparam int unsigned CtrlClearBit = 1;

  localparam int unsigned RoStatus     = 0;
  localparam int unsigned RoCycleCnt   = 1;
  localparam int unsigned RoJobCnt     = 2;
  localparam int unsigned RoLastCycles = 3;

  localparam int unsigned StBusyBit       = 0;
  localparam int unsigned StPendingBit    = 1;
  localparam int unsigned StErrCfgBit     = 2;
  localparam int unsigned StErrTimeoutBit = 3;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWait,
    StRun,
    StDone
  } state_e;

  typedef struct packed {
    logic [CfgModeWidth-1:0] mode;
    logic [CfgDataWidth-1:0] seq_len;
    logic [CfgDataWidth-1:0] d_model;
    logic [CfgDataWidth-1:0] dt_rank;
    logic [CfgDataWidth-1:0] d_inner;
    logic [CfgDataWidth-1:0] d_final;
  } cfg_t;

  function automatic logic [CfgDataWidth-1:0] sat_inc(input logic [CfgDataWidth-1:0] v);
    return (&v) ? v : v + CfgDataWidth'(1);
  endfunction

endpackage

// File: rtl/snax_simbacore_cfg_slot.sv
// One-entry configuration holder; load wins over clear, clear only drops valid.
module snax_simbacore_cfg_slot
  import snax_simbacore_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic load_i,
  input  logic clear_i,
  input  cfg_t data_i,
  output logic valid_o,
  output cfg_t data_o
);

  logic valid_d, valid_q;
  cfg_t data_d, data_q;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end else if (clear_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/snax_simbacore_launch_ctrl.sv
// Launch controller between the SNAX CSR manager and the SimbaCore config port:
// validates launches, queues one pending job, tracks completion and status counters.
module snax_simbacore_launch_ctrl
  import snax_simbacore_pkg::*;
#(
  parameter int unsigned RegRWCount   = 7,
  parameter int unsigned RegROCount   = 4,
  parameter int unsigned RegDataWidth = 32,
  parameter int unsigned ModeWidth    = 13,
  parameter int unsigned BusyTimeout  = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [RegDataWidth-1:0] csr_reg_set_i [RegRWCount],
  input  logic                    csr_reg_set_valid_i,
  output logic                    csr_reg_set_ready_o,
  output logic [RegDataWidth-1:0] csr_reg_ro_set_o [RegROCount],
  output logic                    cfg_valid_o,
  input  logic                    cfg_ready_i,
  output logic [ModeWidth-1:0]    cfg_mode_o,
  output logic [RegDataWidth-1:0] cfg_seq_len_o,
  output logic [RegDataWidth-1:0] cfg_d_model_o,
  output logic [RegDataWidth-1:0] cfg_dt_rank_o,
  output logic [RegDataWidth-1:0] cfg_d_inner_o,
  output logic [RegDataWidth-1:0] cfg_d_final_o,
  input  logic                    core_busy_i
);

  localparam int unsigned TmoWidth = $clog2(BusyTimeout + 1);

  state_e state_d, state_q;
  logic cfg_valid_d, cfg_valid_q;
  logic [TmoWidth-1:0] tmo_d, tmo_q;
  logic [RegDataWidth-1:0] cycle_cnt_d, cycle_cnt_q;
  logic [RegDataWidth-1:0] job_cnt_d, job_cnt_q;
  logic [RegDataWidth-1:0] last_cycles_d, last_cycles_q;
  logic [RegDataWidth-1:0] job_cyc_d, job_cyc_q;
  logic err_cfg_d, err_cfg_q;
  logic err_timeout_d, err_timeout_q;

  logic csr_accept, do_start, do_clear, launch_ok, launch_valid, launch_bad;
  logic active_load, active_clear, pending_load, pending_drain, tmo_hit;
  logic active_valid, pending_valid;
  cfg_t csr_cfg, active_cfg, pending_cfg, active_src;

  assign csr_reg_set_ready_o = ~pending_valid;
  assign csr_accept   = csr_reg_set_valid_i & csr_reg_set_ready_o;
  assign do_start     = csr_accept & csr_reg_set_i[CsrControl][CtrlStartBit];
  assign do_clear     = csr_accept & csr_reg_set_i[CsrControl][CtrlClearBit];
  assign launch_ok    = (csr_cfg.mode != '0) && (csr_cfg.seq_len != '0);
  assign launch_valid = do_start & launch_ok;
  assign launch_bad   = do_start & ~launch_ok;
  assign pending_load = launch_valid & (state_q != StIdle);

  assign csr_cfg.mode    = csr_reg_set_i[CsrMode][ModeWidth-1:0];
  assign csr_cfg.seq_len = csr_reg_set_i[CsrSeqLen];
  assign csr_cfg.d_model = csr_reg_set_i[CsrDModel];
  assign csr_cfg.dt_rank = csr_reg_set_i[CsrDtRank];
  assign csr_cfg.d_inner = csr_reg_set_i[CsrDInner];
  assign csr_cfg.d_final = csr_reg_set_i[CsrDFinal];
  assign active_src      = pending_drain ? pending_cfg : csr_cfg;

  snax_simbacore_cfg_slot i_active_slot (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .load_i  (active_load),
    .clear_i (active_clear),
    .data_i  (active_src),
    .valid_o (active_valid),
    .data_o  (active_cfg)
  );

  snax_simbacore_cfg_slot i_pending_slot (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .load_i  (pending_load),
    .clear_i (pending_drain),
    .data_i  (csr_cfg),
    .valid_o (pending_valid),
    .data_o  (pending_cfg)
  );

  // A job that slipped into the pending slot during DONE is drained from IDLE.
  always_comb begin
    state_d       = state_q;
    tmo_d         = tmo_q;
    active_load   = 1'b0;
    active_clear  = 1'b0;
    pending_drain = 1'b0;
    tmo_hit       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (launch_valid) begin
          active_load = 1'b1;
          state_d     = StIssue;
        end else if (pending_valid) begin
          pending_drain = 1'b1;
          active_load   = 1'b1;
          state_d       = StIssue;
        end
      end
      StIssue: begin
        if (cfg_ready_i) begin
          tmo_d   = '0;
          state_d = StWait;
        end
      end
      StWait: begin
        if (core_busy_i) begin
          state_d = StRun;
        end else if (tmo_q == TmoWidth'(BusyTimeout - 1)) begin
          tmo_hit = 1'b1;
          state_d = StDone;
        end else begin
          tmo_d = tmo_q + TmoWidth'(1);
        end
      end
      StRun: begin
        if (!core_busy_i) state_d = StDone;
      end
      StDone: begin
        if (pending_valid) begin
          pending_drain = 1'b1;
          active_load   = 1'b1;
          state_d       = StIssue;
        end else begin
          active_clear = 1'b1;
          state_d      = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    cfg_valid_d = (state_d == StIssue);
  end

  // Clear wins over same-cycle increments, but a launch error in the same write still lands.
  always_comb begin
    cycle_cnt_d   = (state_q != StIdle) ? sat_inc(cycle_cnt_q) : cycle_cnt_q;
    job_cnt_d     = (state_q == StDone) ? job_cnt_q + RegDataWidth'(1) : job_cnt_q;
    last_cycles_d = (state_q == StDone) ? sat_inc(job_cyc_q) : last_cycles_q;
    job_cyc_d     = (state_q == StIdle || state_q == StDone) ? '0 : sat_inc(job_cyc_q);
    err_timeout_d = err_timeout_q | tmo_hit;
    err_cfg_d     = err_cfg_q;
    if (do_clear) begin
      cycle_cnt_d   = '0;
      job_cnt_d     = '0;
      last_cycles_d = '0;
      err_timeout_d = 1'b0;
      err_cfg_d     = 1'b0;
    end
    err_cfg_d = err_cfg_d | launch_bad;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= StIdle;
      cfg_valid_q   <= 1'b0;
      tmo_q         <= '0;
      cycle_cnt_q   <= '0;
      job_cnt_q     <= '0;
      last_cycles_q <= '0;
      job_cyc_q     <= '0;
      err_cfg_q     <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cfg_valid_q   <= cfg_valid_d;
      tmo_q         <= tmo_d;
      cycle_cnt_q   <= cycle_cnt_d;
      job_cnt_q     <= job_cnt_d;
      last_cycles_q <= last_cycles_d;
      job_cyc_q     <= job_cyc_d;
      err_cfg_q     <= err_cfg_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  always_comb begin
    for (int i = 0; i < RegROCount; i++) csr_reg_ro_set_o[i] = '0;
    csr_reg_ro_set_o[RoStatus][StBusyBit]       = (state_q != StIdle);
    csr_reg_ro_set_o[RoStatus][StPendingBit]    = pending_valid;
    csr_reg_ro_set_o[RoStatus][StErrCfgBit]     = err_cfg_q;
    csr_reg_ro_set_o[RoStatus][StErrTimeoutBit] = err_timeout_q;
    csr_reg_ro_set_o[RoCycleCnt]                = cycle_cnt_q;
    csr_reg_ro_set_o[RoJobCnt]                  = job_cnt_q;
    csr_reg_ro_set_o[RoLastCycles]              = last_cycles_q;
  end

  assign cfg_valid_o   = cfg_valid_q;
  assign cfg_mode_o    = active_cfg.mode;
  assign cfg_seq_len_o = active_cfg.seq_len;
  assign cfg_d_model_o = active_cfg.d_model;
  assign cfg_dt_rank_o = active_cfg.dt_rank;
  assign cfg_d_inner_o = active_cfg.d_inner;
  assign cfg_d_final_o = active_cfg.d_final;

  logic unused_bits;
  assign unused_bits = ^{active_valid,
                         csr_reg_set_i[CsrControl][RegDataWidth-1:2],
                         csr_reg_set_i[CsrMode][RegDataWidth-1:ModeWidth]};

endmodule

// File: tb/tb_snax_simbacore_launch_ctrl.sv
// Directed scenarios with randomized fields and phase lengths; expected counters
// come from summing the job's phase durations rather than tracking controller states.
module tb_snax_simbacore_launch_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] csrSet [7];
  logic        csrValid;
  logic        csrReady;
  logic [31:0] roSet [4];
  logic        cfgValid;
  logic        cfgReady;
  logic [12:0] cfgMode;
  logic [31:0] cfgSeqLen, cfgDModel, cfgDtRank, cfgDInner, cfgDFinal;
  logic        coreBusy;

  int checks = 0;
  int failures = 0;
  int d, w, r, waited, expCycles;
  logic [31:0] nextJob [6];
  logic [31:0] activeJob [6];

  snax_simbacore_launch_ctrl dut (
    .clk_i               (clk_i),
    .rst_i               (rst_i),
    .csr_reg_set_i       (csrSet),
    .csr_reg_set_valid_i (csrValid),
    .csr_reg_set_ready_o (csrReady),
    .csr_reg_ro_set_o    (roSet),
    .cfg_valid_o         (cfgValid),
    .cfg_ready_i         (cfgReady),
    .cfg_mode_o          (cfgMode),
    .cfg_seq_len_o       (cfgSeqLen),
    .cfg_d_model_o       (cfgDModel),
    .cfg_dt_rank_o       (cfgDtRank),
    .cfg_d_inner_o       (cfgDInner),
    .cfg_d_final_o       (cfgDFinal),
    .core_busy_i         (coreBusy)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic newJob(input logic [31:0] mode, input logic [31:0] seqLen);
    nextJob[0] = mode;
    nextJob[1] = seqLen;
    for (int i = 2; i < 6; i++) nextJob[i] = $urandom;
  endtask

  // One CSR write lasting a single edge; callers know whether ready is high.
  task automatic applyStimulus(input bit start, input bit clear);
    for (int i = 0; i < 6; i++) csrSet[i] = nextJob[i];
    csrSet[6] = {30'd0, clear, start};
    csrValid = 1'b1;
    step();
    csrValid = 1'b0;
  endtask

  task automatic checkFields(input string tag);
    checkOutput({tag, ".mode"},   32'(cfgMode), activeJob[0]);
    checkOutput({tag, ".seqLen"}, cfgSeqLen,    activeJob[1]);
    checkOutput({tag, ".dModel"}, cfgDModel,    activeJob[2]);
    checkOutput({tag, ".dtRank"}, cfgDtRank,    activeJob[3]);
    checkOutput({tag, ".dInner"}, cfgDInner,    activeJob[4]);
    checkOutput({tag, ".dFinal"}, cfgDFinal,    activeJob[5]);
  endtask

  // Core withholds ready for 'delay' cycles; config must hold steady meanwhile.
  task automatic driveHandshake(input string tag, input int delay);
    cfgReady = 1'b0;
    for (int i = 0; i < delay; i++) begin
      step();
      checkOutput({tag, ".stallValid"}, 32'(cfgValid), 32'd1);
      checkOutput({tag, ".stallMode"}, 32'(cfgMode), activeJob[0]);
      checkOutput({tag, ".stallSeqLen"}, cfgSeqLen, activeJob[1]);
    end
    cfgReady = 1'b1;
    step();
    cfgReady = 1'b0;
    checkOutput({tag, ".validDrop"}, 32'(cfgValid), 32'd0);
  endtask

  // Busy rises after waitCycles idle cycles, stays high runCycles+1 edges, then falls.
  task automatic runCore(input int waitCycles, input int runCycles);
    coreBusy = 1'b0;
    repeat (waitCycles) step();
    coreBusy = 1'b1;
    step();
    repeat (runCycles) step();
    coreBusy = 1'b0;
    step();
  endtask

  initial begin
    rst_i = 1'b1;
    csrValid = 1'b0;
    cfgReady = 1'b0;
    coreBusy = 1'b0;
    for (int i = 0; i < 7; i++) csrSet[i] = '0;
    for (int i = 0; i < 6; i++) begin
      nextJob[i] = '0;
      activeJob[i] = '0;
    end
    repeat (3) step();

    checkOutput("reset.ready", 32'(csrReady), 32'd1);
    checkOutput("reset.cfgValid", 32'(cfgValid), 32'd0);
    checkOutput("reset.mode", 32'(cfgMode), 32'd0);
    for (int i = 0; i < 4; i++) checkOutput($sformatf("reset.ro%0d", i), roSet[i], 32'd0);
    rst_i = 1'b0;
    step();

    // Single launch with stalled handshake and a busy window of ten cycles
    newJob(32'd1, 32'd8);
    applyStimulus(1'b1, 1'b0);
    activeJob = nextJob;
    checkOutput("single.cfgValid", 32'(cfgValid), 32'd1);
    checkOutput("single.ready", 32'(csrReady), 32'd1);
    checkFields("single");
    d = 3;
    w = $urandom_range(5, 0);
    r = 9;
    driveHandshake("single", d);
    runCore(w, r);
    checkOutput("single.doneBusy", 32'(roSet[0][0]), 32'd1);
    checkOutput("single.jobCntBefore", roSet[2], 32'd0);
    step();
    expCycles = d + w + r + 4;
    checkOutput("single.jobCnt", roSet[2], 32'd1);
    checkOutput("single.lastCycles", roSet[3], 32'(expCycles));
    checkOutput("single.cycleCnt", roSet[1], 32'(expCycles));
    checkOutput("single.status", roSet[0], 32'd0);

    // Invalid launches are dropped and flag err_cfg
    newJob(32'd0, 32'($urandom_range(1000, 1)));
    applyStimulus(1'b1, 1'b0);
    checkOutput("invMode.cfgValid", 32'(cfgValid), 32'd0);
    checkOutput("invMode.status", roSet[0], 32'd4);
    checkOutput("invMode.ready", 32'(csrReady), 32'd1);
    step();
    checkOutput("invMode.cfgValidLater", 32'(cfgValid), 32'd0);
    newJob(32'($urandom_range(8191, 1)), 32'd0);
    applyStimulus(1'b1, 1'b0);
    checkOutput("invSeq.cfgValid", 32'(cfgValid), 32'd0);
    checkOutput("invSeq.status", roSet[0], 32'd4);
    checkOutput("invSeq.ready", 32'(csrReady), 32'd1);
    applyStimulus(1'b0, 1'b1);
    for (int i = 0; i < 4; i++) checkOutput($sformatf("clear.ro%0d", i), roSet[i], 32'd0);
    checkOutput("clear.cfgValid", 32'(cfgValid), 32'd0);

    // Back-to-back: second launch queues behind the running job
    newJob(32'($urandom_range(8191, 1)), 32'($urandom_range(1000, 1)));
    applyStimulus(1'b1, 1'b0);
    activeJob = nextJob;
    driveHandshake("b2bA", $urandom_range(3, 0));
    coreBusy = 1'b1;
    step();
    newJob(32'($urandom_range(8191, 1)), 32'($urandom_range(1000, 1)));
    applyStimulus(1'b1, 1'b0);
    checkOutput("b2b.readyLow", 32'(csrReady), 32'd0);
    checkOutput("b2b.status", roSet[0], 32'd3);
    checkFields("b2b.firstHeld");
    repeat ($urandom_range(5, 0)) step();
    coreBusy = 1'b0;
    step();
    checkOutput("b2b.doneValid", 32'(cfgValid), 32'd0);
    checkOutput("b2b.doneReady", 32'(csrReady), 32'd0);
    step();
    activeJob = nextJob;
    checkOutput("b2b.secondValid", 32'(cfgValid), 32'd1);
    checkOutput("b2b.readyBack", 32'(csrReady), 32'd1);
    checkOutput("b2b.jobCnt1", roSet[2], 32'd1);
    checkFields("b2b.second");
    driveHandshake("b2bB", 0);
    runCore(0, 0);
    step();
    checkOutput("b2b.jobCnt2", roSet[2], 32'd2);
    checkOutput("b2b.lastCycles", roSet[3], 32'd4);
    checkOutput("b2b.status", roSet[0], 32'd0);

    // Timeout: the core never raises busy
    applyStimulus(1'b0, 1'b1);
    newJob(32'($urandom_range(8191, 1)), 32'($urandom_range(1000, 1)));
    applyStimulus(1'b1, 1'b0);
    activeJob = nextJob;
    d = $urandom_range(3, 0);
    driveHandshake("tmo", d);
    coreBusy = 1'b0;
    waited = 0;
    while (roSet[0][3] !== 1'b1 && waited < 40) begin
      step();
      waited++;
    end
    checkOutput("tmo.waitCycles", 32'(waited), 32'd16);
    checkOutput("tmo.doneBusy", 32'(roSet[0][0]), 32'd1);
    step();
    checkOutput("tmo.status", roSet[0], 32'd8);
    checkOutput("tmo.jobCnt", roSet[2], 32'd1);
    checkOutput("tmo.lastCycles", roSet[3], 32'(d + 18));

    // Build up exactly fifty busy cycles, then clear and start in one write
    applyStimulus(1'b0, 1'b1);
    newJob(32'($urandom_range(8191, 1)), 32'($urandom_range(1000, 1)));
    applyStimulus(1'b1, 1'b0);
    activeJob = nextJob;
    d = $urandom_range(10, 0);
    w = $urandom_range(10, 0);
    r = 46 - d - w;
    driveHandshake("fifty", d);
    runCore(w, r);
    step();
    checkOutput("fifty.cycleCnt", roSet[1], 32'd50);
    checkOutput("fifty.lastCycles", roSet[3], 32'd50);
    newJob(32'($urandom_range(8191, 1)), 32'($urandom_range(1000, 1)));
    applyStimulus(1'b1, 1'b1);
    activeJob = nextJob;
    checkOutput("clrStart.cfgValid", 32'(cfgValid), 32'd1);
    checkOutput("clrStart.cycleCnt", roSet[1], 32'd0);
    checkOutput("clrStart.jobCnt", roSet[2], 32'd0);
    checkOutput("clrStart.lastCycles", roSet[3], 32'd0);
    checkOutput("clrStart.status", roSet[0], 32'd1);
    checkFields("clrStart");
    d = $urandom_range(4, 0);
    w = $urandom_range(6, 0);
    r = $urandom_range(8, 0);
    driveHandshake("clrStart", d);
    runCore(w, r);
    step();
    checkOutput("clrStart.cycleCntEnd", roSet[1], 32'(d + w + r + 4));
    checkOutput("clrStart.jobCntEnd", roSet[2], 32'd1);
    checkOutput("clrStart.statusEnd", roSet[0], 32'd0);

    // Reset in the middle of RUN with a pending job queued
    newJob(32'($urandom_range(8191, 1)), 32'($urandom_range(1000, 1)));
    applyStimulus(1'b1, 1'b0);
    activeJob = nextJob;
    driveHandshake("rstRun", 1);
    coreBusy = 1'b1;
    step();
    newJob(32'($urandom_range(8191, 1)), 32'($urandom_range(1000, 1)));
    applyStimulus(1'b1, 1'b0);
    checkOutput("rstRun.readyLow", 32'(csrReady), 32'd0);
    #2;
    rst_i = 1'b1;
    #1;
    checkOutput("rstRun.cfgValid", 32'(cfgValid), 32'd0);
    checkOutput("rstRun.ready", 32'(csrReady), 32'd1);
    checkOutput("rstRun.mode", 32'(cfgMode), 32'd0);
    checkOutput("rstRun.seqLen", cfgSeqLen, 32'd0);
    for (int i = 0; i < 4; i++) checkOutput($sformatf("rstRun.ro%0d", i), roSet[i], 32'd0);
    coreBusy = 1'b0;
    step();
    rst_i = 1'b0;
    step();
    checkOutput("rstRun.idleAfter", roSet[0], 32'd0);
    checkOutput("rstRun.cfgValidAfter", 32'(cfgValid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
